// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Imported by the arbiter top, its round-robin selector and the bench.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int MEM_ADDR_W = 20;
    localparam int LINE_W     = 128;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: combinational grant plus a registered
// pointer to the port granted last (reset favours the data port).
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic       valid,
    output logic       grant
);

    logic last;

    always_comb begin
        valid = |req;
        unique case (req)
            2'b11:   grant = ~last;
            2'b01:   grant = PORT_I;
            default: grant = PORT_D;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last <= PORT_I;
        end else if (take) begin
            last <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction and a data cache onto one line-wide memory,
// with flush/timeout abort and a sticky timeout error.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [MEM_ADDR_W-1:0] i_addr,
    input  logic [LINE_W-1:0]     i_wdata,
    output logic                  i_ack,
    output logic [LINE_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [MEM_ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0]     d_wdata,
    output logic                  d_ack,
    output logic [LINE_W-1:0]     d_rdata,
    output logic                  mem_requested,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]     mem_wdata,
    output logic                  mem_reset_req,
    input  logic                  mem_ready,
    input  logic [LINE_W-1:0]     mem_rdata,
    input  logic                  loading,
    input  logic                  flush,
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    state_t        state;
    logic          port_q;
    logic          we_q;
    logic          seen_low;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          gnt_valid;
    logic          gnt_port;
    logic          take;
    logic          done;
    logic          unused_i_we;

    // The instruction port is read-only; its write enable is ignored.
    assign unused_i_we = i_we;

    assign take    = (state == S_IDLE) && !loading && gnt_valid;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign done    = seen_low && mem_ready;

    rr_arbiter2 u_rr (
        .clk   (clk),
        .reset (reset),
        .req   ({d_req, i_req}),
        .take  (take),
        .valid (gnt_valid),
        .grant (gnt_port)
    );

    // Drops as soon as mem_ready returns so the memory never relaunches.
    assign mem_requested = (state == S_ISSUE) ||
                           (state == S_BUSY && !mem_ready);
    assign mem_we  = we_q && (state == S_ISSUE || state == S_BUSY);
    assign i_rdata = i_ack ? mem_rdata : '0;
    assign d_rdata = d_ack ? mem_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            port_q        <= PORT_D;
            we_q          <= 1'b0;
            seen_low      <= 1'b0;
            cnt           <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            i_ack         <= 1'b0;
            d_ack         <= 1'b0;
            mem_reset_req <= 1'b0;
            timeout_err   <= 1'b0;
        end else begin
            i_ack         <= 1'b0;
            d_ack         <= 1'b0;
            mem_reset_req <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (take) begin
                        state  <= S_ISSUE;
                        port_q <= gnt_port;
                        if (gnt_port == PORT_D) begin
                            we_q      <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            we_q      <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= i_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt      <= '0;
                    seen_low <= 1'b0;
                    if (flush) begin
                        state         <= S_IDLE;
                        mem_reset_req <= 1'b1;
                    end else begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt_inc;
                    if (!mem_ready) begin
                        seen_low <= 1'b1;
                    end
                    if (flush) begin
                        state         <= S_IDLE;
                        mem_reset_req <= 1'b1;
                    end else if (done) begin
                        state <= S_RESP;
                        i_ack <= (port_q == PORT_I);
                        d_ack <= (port_q == PORT_D);
                    end else if (cnt_inc == CNT_MAX) begin
                        state         <= S_IDLE;
                        mem_reset_req <= 1'b1;
                        timeout_err   <= 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction table plus hand-built
// sequences for arbitration, flush, loading, timeout and reset.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam logic [127:0] A5  = {16{8'hA5}};
    localparam logic [127:0] L11 = {16{8'h11}};
    localparam logic [127:0] W1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] ONES = {128{1'b1}};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         i_req = 0, i_we = 0, d_req = 0, d_we = 0;
    logic [19:0]  i_addr = '0, d_addr = '0;
    logic [127:0] i_wdata = '0, d_wdata = '0;
    logic         i_ack, d_ack;
    logic [127:0] i_rdata, d_rdata;
    logic         mem_requested, mem_we, mem_reset_req;
    logic [19:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_ready = 1'b1;
    logic [127:0] mem_rdata = '0;
    logic         loading = 0, flush = 0;
    logic         timeout_err;

    int applied = 0;
    int miscompares = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_we(i_we), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_requested(mem_requested), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_reset_req(mem_reset_req), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .loading(loading), .flush(flush), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // 5-cycle memory model, updated on the falling edge.
    logic [127:0] store [logic [19:0]];
    logic         mbusy = 0, mwe = 0, stuck = 0;
    logic [19:0]  maddr = '0;
    logic [127:0] mwd = '0;
    int           mcnt = 0;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            mbusy = 0;
            mem_ready = 1;
            store[20'h00010] = A5;
            store[20'h00100] = L11;
        end else if (mem_reset_req) begin
            mbusy = 0;
            mem_ready = 1;
        end else if (mbusy) begin
            if (!stuck) begin
                if (mcnt == 0) begin
                    mbusy = 0;
                    mem_ready = 1;
                    if (mwe) begin
                        store[maddr] = mwd;
                        mem_rdata = '0;
                    end else begin
                        mem_rdata = store.exists(maddr) ? store[maddr] : '0;
                    end
                end else begin
                    mcnt = mcnt - 1;
                end
            end
        end else if (mem_requested && mem_ready) begin
            mbusy = 1;
            mcnt = 5;
            mem_ready = 0;
            maddr = mem_addr;
            mwe = mem_we;
            mwd = mem_wdata;
        end
    end

    typedef struct packed {
        logic         port;
        logic         we;
        logic [19:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input logic port, input logic we,
                       input logic [19:0] addr, input logic [127:0] wdata,
                       input logic [127:0] exp_rd, input string tag);
        int           lat;
        logic [1:0]   acks;
        logic [127:0] rd;
        if (port == PORT_D) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1; i_we = we; i_addr = addr; i_wdata = wdata;
        end
        tick();
        check({tag, ":t1_addr"}, mem_addr, addr);
        check({tag, ":t1_we"}, mem_we, (port == PORT_D) ? we : 1'b0);
        check({tag, ":t1_req"}, mem_requested, 1'b1);
        check({tag, ":t1_rdata0"}, i_rdata | d_rdata, '0);
        lat = 1;
        while (!(i_ack || d_ack) && lat < 40) begin
            tick();
            lat++;
        end
        acks = {d_ack, i_ack};
        rd = port ? d_rdata : i_rdata;
        d_req = 0;
        i_req = 0;
        check({tag, ":latency"}, lat, 8);
        check({tag, ":acks"}, acks, port ? 2'b10 : 2'b01);
        check({tag, ":rdata"}, rd, exp_rd);
        tick();
    endtask

    task automatic both_req(input logic first, input string tag);
        int           ti, td, overlap;
        logic [127:0] ri, rdd;
        ti = 0; td = 0; overlap = 0; ri = '0; rdd = '0;
        i_req = 1; i_we = 0; i_addr = 20'h00100;
        d_req = 1; d_we = 0; d_addr = 20'h00010;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (i_ack && d_ack) overlap = 1;
            if (d_ack && td == 0) begin td = k; rdd = d_rdata; d_req = 0; end
            if (i_ack && ti == 0) begin ti = k; ri = i_rdata; i_req = 0; end
        end
        check({tag, ":d_ack_at"}, td, (first == PORT_D) ? 8 : 17);
        check({tag, ":i_ack_at"}, ti, (first == PORT_I) ? 8 : 17);
        check({tag, ":d_rdata"}, rdd, A5);
        check({tag, ":i_rdata"}, ri, L11);
        check({tag, ":overlap"}, overlap, 0);
    endtask

    initial begin
        int   hits;
        int   rr;
        logic seen;

        tbl[0] = '{PORT_D, 1'b0, 20'h00010, '0,   A5};
        tbl[1] = '{PORT_D, 1'b1, 20'h00020, W1,   '0};
        tbl[2] = '{PORT_D, 1'b0, 20'h00020, '0,   W1};
        tbl[3] = '{PORT_I, 1'b1, 20'h00020, ONES, W1};
        tbl[4] = '{PORT_I, 1'b0, 20'h00100, '0,   L11};
        tbl[5] = '{PORT_D, 1'b1, 20'hFFFFF, ONES, '0};
        tbl[6] = '{PORT_I, 1'b0, 20'hFFFFF, '0,   ONES};
        tbl[7] = '{PORT_D, 1'b0, 20'h00100, '0,   L11};

        #2 reset = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:acks", {i_ack, d_ack}, 2'b00);
        check("rst:mem_req", mem_requested, 1'b0);
        check("rst:mem_we", mem_we, 1'b0);
        check("rst:mem_reset_req", mem_reset_req, 1'b0);
        check("rst:timeout_err", timeout_err, 1'b0);
        check("rst:mem_addr", mem_addr, '0);
        check("rst:mem_wdata", mem_wdata, '0);
        reset = 1;
        tick();

        both_req(PORT_D, "rr_after_reset");

        for (int v = 0; v < 8; v++) begin
            txn(tbl[v].port, tbl[v].we, tbl[v].addr, tbl[v].wdata,
                tbl[v].rdata, $sformatf("vec%0d", v));
        end

        both_req(PORT_I, "rr_after_d");

        flush = 1;
        tick();
        flush = 0;
        check("flush_idle:reset_req", mem_reset_req, 1'b0);

        d_req = 1; d_we = 0; d_addr = 20'h00010;
        repeat (4) tick();
        check("flush:t4_req", mem_requested, 1'b1);
        flush = 1;
        tick();
        flush = 0;
        d_req = 0;
        check("flush:t5_reset_req", mem_reset_req, 1'b1);
        check("flush:t5_idle", mem_requested, 1'b0);
        seen = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) check("flush:t6_pulse_end", mem_reset_req, 1'b0);
            if (i_ack || d_ack) seen = 1;
        end
        check("flush:no_ack", seen, 1'b0);
        txn(PORT_D, 1'b0, 20'h00010, '0, A5, "after_flush");

        loading = 1;
        i_req = 1; i_we = 0; i_addr = 20'h00100;
        seen = 0;
        repeat (6) begin
            tick();
            if (mem_requested) seen = 1;
        end
        check("load:blocked", seen, 1'b0);
        loading = 0;
        tick();
        check("load:issue_next", mem_requested, 1'b1);
        loading = 1;
        hits = 1;
        while (!(i_ack || d_ack) && hits < 40) begin
            tick();
            hits++;
        end
        check("load:midtxn_lat", hits, 8);
        check("load:midtxn_rdata", i_rdata, L11);
        i_req = 0;
        loading = 0;
        tick();

        stuck = 1;
        d_req = 1; d_we = 0; d_addr = 20'h00010;
        rr = 0; hits = 0; seen = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 16) check("tmo:t16_err", timeout_err, 1'b0);
            if (i_ack || d_ack) seen = 1;
            if (mem_reset_req) begin
                hits++;
                if (rr == 0) begin
                    rr = k;
                    d_req = 0;
                    stuck = 0;
                    check("tmo:err_set", timeout_err, 1'b1);
                end
            end
        end
        check("tmo:reset_req_at", rr, 17);
        check("tmo:single_pulse", hits, 1);
        check("tmo:no_ack", seen, 1'b0);
        txn(PORT_D, 1'b0, 20'h00020, '0, W1, "after_tmo");
        check("tmo:sticky", timeout_err, 1'b1);

        d_req = 1; d_we = 0; d_addr = 20'h00010;
        repeat (4) tick();
        reset = 0;
        #1;
        check("rst_mid:mem_req", mem_requested, 1'b0);
        check("rst_mid:err_clr", timeout_err, 1'b0);
        check("rst_mid:mem_addr", mem_addr, '0);
        d_req = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        seen = 0;
        repeat (10) begin
            tick();
            if (i_ack || d_ack) seen = 1;
        end
        check("rst_mid:no_ack", seen, 1'b0);
        both_req(PORT_D, "rr_after_rst_mid");

        $display("== %0d vectors applied, %0d miscompares ==",
                 applied, miscompares);
        $finish;
    end

endmodule
